snoop_bus_arbiter: RTL and testbench

Shared snoop-bus stage that sits directly downstream of the per-core caches. It collects each cache's `bus_tx` / `bus_tx_enable` request and arbitrates between caches with a round-robin policy. It broadcasts the winning message to every cache for `BUS_LATENCY` cycles, then returns a one-cycle `bus_tx_sent` pulse to the winner. Exactly one message occupies the bus at a time.

---
 rtl/snoop_bus_pkg.sv | 28 ++
 rtl/snoop_bus_arbiter_rr_arbiter.sv | 31 +++
 rtl/snoop_bus_arbiter.sv | 139 +++++++++++++
 tb/tb_snoop_bus_arbiter.sv | 290 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snoop_bus_pkg.sv
// Shared snoop-bus types: message field offsets, op codes, FSM states.
// Message layout: {rsvd, addr, op, valid, id[1:0]}.
package snoop_bus_pkg;

  localparam int ID_LSB    = 0;
  localparam int ID_W      = 2;
  localparam int VALID_BIT = 2;
  localparam int OP_BIT    = 3;
  localparam int ADDR_LSB  = 4;

  localparam logic OP_READ  = 1'b1;
  localparam logic OP_WRITE = 1'b0;

  typedef enum logic [1:0] {
    IDLE,
    GRANT,
    DONE
  } bus_state_e;

  function automatic int msg_width(input int addr_width);
    return addr_width + 5;
  endfunction

  function automatic int rsvd_bit(input int addr_width);
    return addr_width + 4;
  endfunction

endpackage

// File: rtl/snoop_bus_arbiter_rr_arbiter.sv
// Round-robin pick: search starts one past last_grant, wraps at N.
// Ports: req, last_grant in; one-hot grant and grant_idx out.
module rr_arbiter #(
  parameter  int N  = 4,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last_grant,
  output logic [N-1:0]  grant,
  output logic [IW-1:0] grant_idx
);

  logic           found;
  logic [IW-1:0]  idx;

  always_comb begin
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    idx       = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(last_grant) + k) % N);
      if (!found && req[idx]) begin
        found      = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/snoop_bus_arbiter.sv
// Snoop bus: round-robin grant, broadcast BUS_LATENCY cycles, ack.
// Ports: clock, reset, req_tx/req_enable in; req_sent, bus_rx,
// bus_rx_valid, bus_rx_src, busy out. SNOOP_BUS_PERF_EN adds
// perf_grants / perf_conflicts saturating counters.
module snoop_bus_arbiter
  import snoop_bus_pkg::*;
#(
  parameter  int N_CACHES    = 4,
  parameter  int ADDR_WIDTH  = 8,
  parameter  int BUS_LATENCY = 1,
  localparam int MW          = msg_width(ADDR_WIDTH),
  localparam int IW          = $clog2(N_CACHES)
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [N_CACHES*MW-1:0] req_tx,
  input  logic [N_CACHES-1:0]    req_enable,
  output logic [N_CACHES-1:0]    req_sent,
  output logic [MW-1:0]          bus_rx,
  output logic                   bus_rx_valid,
  output logic [IW-1:0]          bus_rx_src,
  output logic                   busy
`ifdef SNOOP_BUS_PERF_EN
  ,
  output logic [31:0]            perf_grants,
  output logic [31:0]            perf_conflicts
`endif
);

  localparam int HW = $clog2(BUS_LATENCY) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(BUS_LATENCY - 1);
  localparam int RSVD = rsvd_bit(ADDR_WIDTH);

  bus_state_e            state;
  logic [HW-1:0]         hold_cnt;
  logic [MW-1:0]         msg_q;
  logic [IW-1:0]         src_q;
  logic [IW-1:0]         last_grant;

  logic [N_CACHES-1:0]   gnt_oh;
  logic [IW-1:0]         gnt_idx;
  logic [MW-1:0]         win_msg;
  logic                  any_req;

  assign any_req = |req_enable;

  rr_arbiter #(
    .N (N_CACHES)
  ) u_arb (
    .req        (req_enable),
    .last_grant (last_grant),
    .grant      (gnt_oh),
    .grant_idx  (gnt_idx)
  );

  // One-hot mux of the winning slice; reserved bit always sent as 0.
  always_comb begin
    win_msg = '0;
    for (int i = 0; i < N_CACHES; i++) begin
      if (gnt_oh[i]) win_msg = win_msg | req_tx[i*MW +: MW];
    end
    win_msg[RSVD] = 1'b0;
  end

  // Outputs are loaded on the same edges that move the FSM, so they
  // always line up with the state they describe.
  always_ff @(posedge clock) begin
    if (reset) begin
      state        <= IDLE;
      hold_cnt     <= '0;
      msg_q        <= '0;
      src_q        <= '0;
      last_grant   <= IW'(N_CACHES - 1);
      req_sent     <= '0;
      bus_rx       <= '0;
      bus_rx_valid <= 1'b0;
      bus_rx_src   <= '0;
      busy         <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (any_req) begin
            state        <= GRANT;
            hold_cnt     <= '0;
            msg_q        <= win_msg;
            src_q        <= gnt_idx;
            last_grant   <= gnt_idx;
            bus_rx       <= win_msg;
            bus_rx_valid <= win_msg[VALID_BIT];
            bus_rx_src   <= gnt_idx;
            busy         <= 1'b1;
          end
        end
        GRANT: begin
          if (hold_cnt == HOLD_LAST) begin
            state        <= DONE;
            hold_cnt     <= '0;
            bus_rx       <= '0;
            bus_rx_valid <= 1'b0;
            bus_rx_src   <= '0;
            req_sent     <= N_CACHES'(1) << src_q;
          end else begin
            hold_cnt <= hold_cnt + 1'b1;
          end
        end
        DONE: begin
          state    <= IDLE;
          req_sent <= '0;
          busy     <= 1'b0;
        end
        default: begin
          state    <= IDLE;
          req_sent <= '0;
          busy     <= 1'b0;
        end
      endcase
    end
  end

`ifdef SNOOP_BUS_PERF_EN
  logic multi_req;

  // More than one bit set: clearing the lowest set bit leaves a one.
  assign multi_req = |(req_enable & (req_enable - 1'b1));

  always_ff @(posedge clock) begin
    if (reset) begin
      perf_grants    <= '0;
      perf_conflicts <= '0;
    end else if (state == IDLE && any_req) begin
      if (perf_grants != '1)
        perf_grants <= perf_grants + 1'b1;
      if (multi_req && perf_conflicts != '1)
        perf_conflicts <= perf_conflicts + 1'b1;
    end
  end
`endif

endmodule

// File: tb/tb_snoop_bus_arbiter.sv
// Directed bench for snoop_bus_arbiter at BUS_LATENCY 1 and 3.
// Scoreboard of expected grants, checked by immediate assertions.
module tb_snoop_bus_arbiter;

  localparam int N  = 4;
  localparam int MW = 13;

  typedef struct {
    logic [1:0]    src;
    logic [MW-1:0] msg;
  } exp_t;

  logic            clock;
  logic            reset;
  logic [N*MW-1:0] req_tx;
  logic [N-1:0]    req_enable;

  logic [N-1:0]    s1_sent, s3_sent;
  logic [MW-1:0]   s1_rx, s3_rx;
  logic            s1_valid, s3_valid;
  logic [1:0]      s1_src, s3_src;
  logic            s1_busy, s3_busy;
`ifdef SNOOP_BUS_PERF_EN
  logic [31:0]     p1_grants, p1_conf;
  logic [31:0]     p3_grants, p3_conf;
`endif

  logic            sel;
  logic [N-1:0]    o_sent;
  logic [MW-1:0]   o_rx;
  logic            o_valid;
  logic [1:0]      o_src;
  logic            o_busy;
  int              lat;

  exp_t            sb[$];
  logic [MW-1:0]   tx_next [N];
  int              left [N];
  int              n_assert;
  int              n_fail;

  snoop_bus_arbiter #(
    .N_CACHES(4), .ADDR_WIDTH(8), .BUS_LATENCY(1)
  ) dut1 (
    .clock(clock), .reset(reset),
    .req_tx(req_tx), .req_enable(req_enable),
    .req_sent(s1_sent), .bus_rx(s1_rx),
    .bus_rx_valid(s1_valid), .bus_rx_src(s1_src),
    .busy(s1_busy)
`ifdef SNOOP_BUS_PERF_EN
    , .perf_grants(p1_grants), .perf_conflicts(p1_conf)
`endif
  );

  snoop_bus_arbiter #(
    .N_CACHES(4), .ADDR_WIDTH(8), .BUS_LATENCY(3)
  ) dut3 (
    .clock(clock), .reset(reset),
    .req_tx(req_tx), .req_enable(req_enable),
    .req_sent(s3_sent), .bus_rx(s3_rx),
    .bus_rx_valid(s3_valid), .bus_rx_src(s3_src),
    .busy(s3_busy)
`ifdef SNOOP_BUS_PERF_EN
    , .perf_grants(p3_grants), .perf_conflicts(p3_conf)
`endif
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always_comb begin
    o_sent  = sel ? s3_sent  : s1_sent;
    o_rx    = sel ? s3_rx    : s1_rx;
    o_valid = sel ? s3_valid : s1_valid;
    o_src   = sel ? s3_src   : s1_src;
    o_busy  = sel ? s3_busy  : s1_busy;
    lat     = sel ? 3 : 1;
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [MW-1:0] mk(input logic [1:0] id,
                                       input logic v,
                                       input logic op,
                                       input logic [7:0] a,
                                       input logic r);
    return {r, a, op, v, id};
  endfunction

  task automatic send(input int i, input logic [MW-1:0] m,
                      input int n);
    req_tx[i*MW +: MW] = m;
    req_enable[i] = 1'b1;
    left[i] = n;
  endtask

  task automatic push(input int i, input logic [MW-1:0] m);
    exp_t e;
    e.src = 2'(i);
    e.msg = m;
    e.msg[MW-1] = 1'b0;
    sb.push_back(e);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    req_enable = '0;
    req_tx = '0;
    for (int i = 0; i < N; i++) left[i] = 0;
    @(negedge clock);
    reset = 1'b0;
  endtask

  // Per-cycle monitor plus requester model; returns once the queue
  // is drained and the bus is back to idle, or the budget runs out.
  task automatic run(input string tg, input int budget,
                     input bit chk_gap, input bit scramble);
    exp_t cur;
    logic pb;
    bit   active, have_g, done;
    int   last_g, hold, s;
    cur.src = '0;
    cur.msg = '0;
    pb = 1'b0; active = 0; have_g = 0; done = 0;
    last_g = 0; hold = 0;
    for (int cyc = 0; cyc < budget; cyc++) begin
      @(negedge clock);
      if (o_busy && !pb) begin
        chk({tg, "_grant_expected"}, 32'(sb.size() != 0), 1);
        if (sb.size() != 0) cur = sb.pop_front();
        if (chk_gap && have_g)
          chk({tg, "_gap"}, cyc - last_g, lat + 2);
        last_g = cyc; have_g = 1; active = 1; hold = 0;
        if (scramble) begin
          s = int'(cur.src);
          req_tx[s*MW +: MW] = ~req_tx[s*MW +: MW];
        end
      end
      if (active && o_busy && o_sent == '0) begin
        hold++;
        chk({tg, "_rx"}, 32'(o_rx), 32'(cur.msg));
        chk({tg, "_valid"}, 32'(o_valid), 32'(cur.msg[2]));
        chk({tg, "_src"}, 32'(o_src), 32'(cur.src));
      end else if (active && o_sent != '0) begin
        chk({tg, "_sent"}, 32'(o_sent), 32'(4'b1 << cur.src));
        chk({tg, "_hold"}, hold, lat);
        chk({tg, "_done_valid"}, 32'(o_valid), 0);
        active = 0;
        s = int'(cur.src);
        left[s]--;
        if (left[s] <= 0) req_enable[s] = 1'b0;
        else req_tx[s*MW +: MW] = tx_next[s];
      end else if (o_sent != '0) begin
        chk({tg, "_spurious_sent"}, 32'(o_sent), 0);
      end
      pb = o_busy;
      if (sb.size() == 0 && !active && !o_busy) begin
        done = 1;
        break;
      end
    end
    chk({tg, "_completed"}, 32'(done), 1);
  endtask

  initial begin
    logic [MW-1:0] m0, m1, m2, m3, mb;
    n_assert = 0;
    n_fail = 0;
    sel = 1'b0;
    reset = 1'b1;
    req_tx = '0;
    req_enable = '0;
    for (int i = 0; i < N; i++) begin
      left[i] = 0;
      tx_next[i] = '0;
    end
    repeat (2) @(negedge clock);
    reset = 1'b0;

    // Reset state
    chk("rst_sent", 32'(s1_sent), 0);
    chk("rst_rx", 32'(s1_rx), 0);
    chk("rst_valid", 32'(s1_valid), 0);
    chk("rst_src", 32'(s1_src), 0);
    chk("rst_busy", 32'(s1_busy), 0);
    chk("rst_busy3", 32'(s3_busy), 0);
`ifdef SNOOP_BUS_PERF_EN
    chk("rst_perf_g", p1_grants, 0);
    chk("rst_perf_c", p1_conf, 0);
`endif

    // Single read from cache 2, latency 1
    sel = 1'b0;
    m2 = mk(2'd2, 1'b1, 1'b1, 8'h5A, 1'b0);
    send(2, m2, 1);
    push(2, m2);
    run("single", 20, 0, 0);
    @(negedge clock);
    chk("single_idle", 32'(o_busy), 0);

    // Four-way contention; cache 0 sends a second message
    do_reset();
    m0 = mk(2'd0, 1'b1, 1'b1, 8'h10, 1'b1);
    m1 = mk(2'd1, 1'b1, 1'b0, 8'h21, 1'b1);
    m2 = mk(2'd2, 1'b1, 1'b1, 8'h32, 1'b0);
    m3 = mk(2'd3, 1'b1, 1'b0, 8'h43, 1'b1);
    mb = mk(2'd0, 1'b1, 1'b0, 8'hE7, 1'b0);
    tx_next[0] = mb;
    send(0, m0, 2);
    send(1, m1, 1);
    send(2, m2, 1);
    send(3, m3, 1);
    push(0, m0);
    push(1, m1);
    push(2, m2);
    push(3, m3);
    push(0, mb);
    run("rr4", 80, 1, 0);
`ifdef SNOOP_BUS_PERF_EN
    chk("perf_grants", p1_grants, 5);
    chk("perf_conflicts", p1_conf, 4);
`endif

    // Latency 3, cache 1 changes req_tx while granted
    sel = 1'b1;
    do_reset();
    m1 = mk(2'd1, 1'b1, 1'b0, 8'hC3, 1'b0);
    send(1, m1, 1);
    push(1, m1);
    run("hold3", 30, 0, 1);

    // Valid bit clear: full sequence, no bus_rx_valid
    sel = 1'b0;
    do_reset();
    m0 = mk(2'd0, 1'b0, 1'b1, 8'h33, 1'b0);
    send(0, m0, 1);
    push(0, m0);
    run("novalid", 20, 0, 0);

    // Reset in the second GRANT cycle aborts the message
    sel = 1'b1;
    do_reset();
    m1 = mk(2'd1, 1'b1, 1'b1, 8'h77, 1'b0);
    send(1, m1, 1);
    for (int c = 0; c < 10; c++) begin
      @(negedge clock);
      if (o_busy) break;
    end
    chk("abort_busy", 32'(o_busy), 1);
    @(negedge clock);
    chk("abort_grant2_sent", 32'(o_sent), 0);
    chk("abort_grant2_rx", 32'(o_rx), 32'(m1));
    reset = 1'b1;
    req_enable = '0;
    left[1] = 0;
    @(negedge clock);
    reset = 1'b0;
    chk("abort_sent", 32'(o_sent), 0);
    chk("abort_rx", 32'(o_rx), 0);
    chk("abort_valid", 32'(o_valid), 0);
    chk("abort_src", 32'(o_src), 0);
    chk("abort_busy0", 32'(o_busy), 0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clock);
      chk("abort_no_sent", 32'(o_sent), 0);
    end
    // last_grant back to 3: cache 0 must beat cache 3
    m0 = mk(2'd0, 1'b1, 1'b0, 8'hA0, 1'b0);
    m3 = mk(2'd3, 1'b1, 1'b1, 8'h3C, 1'b0);
    send(0, m0, 1);
    send(3, m3, 1);
    push(0, m0);
    push(3, m3);
    run("after_abort", 40, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_assert, n_fail);
    $finish;
  end

endmodule
